// File: rtl/carry_propagation.sv
// Resolves carries in the pre-bitstream word stream: one held byte plus a
// pending-0xFF run, emitting final bytes one per cycle. Optional CARRY_ERR_CHECK_EN.
module carry_propagation #(
  parameter int RANGE_WIDTH   = 16,
  parameter int RUN_CNT_WIDTH = 16
) (
  input  logic                   general_clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_flag_1,
  input  logic [1:0]             in_flag_2,
  input  logic [RANGE_WIDTH-1:0] in_bit_1_1,
  input  logic [RANGE_WIDTH-1:0] in_bit_1_2,
  input  logic [RANGE_WIDTH-1:0] in_bit_2_1,
  input  logic [RANGE_WIDTH-1:0] in_bit_2_2,
  input  logic                   flush,
  output logic [7:0]             out_byte,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   flush_done,
  output logic [1:0]             err
);

  // state      | meaning
  // ACCEPT     | consume one staged word per cycle, or act on a pending flush
  // EMIT_HELD  | present the resolved held byte
  // EMIT_RUN   | present the resolved fill bytes of the pending run
  // FLUSH_HELD | present the held byte at end of stream
  // FLUSH_RUN  | present the pending 0xFF bytes at end of stream
  typedef enum logic [2:0] {ACCEPT, EMIT_HELD, EMIT_RUN, FLUSH_HELD, FLUSH_RUN} state_t;

  localparam logic [RUN_CNT_WIDTH-1:0] RUN_ONE = 1;

  state_t state, state_nxt;

  logic       stg_valid;
  logic [1:0] stg_n1;
  logic [2:0] stg_cnt, stg_idx;
  logic [8:0] stg_w11, stg_w12, stg_w21, stg_w22;

  logic [7:0]               held;
  logic                     hv;
  logic [RUN_CNT_WIDTH-1:0] pend;
  logic [7:0]               emit_byte;
  logic [7:0]               fill;
  logic [RUN_CNT_WIDTH-1:0] emit_run;
  logic                     flush_pend;

  logic [1:0] eff_1, eff_2;
  logic [8:0] cur_word;
  logic       cur_c;
  logic [7:0] cur_b;
  logic       consume, word_emits, last_word, stg_clear, load;
  logic       flush_go, hs, flush_fin, flag_bad;
  logic       unused_hi;

  assign unused_hi = ^{in_bit_1_1[RANGE_WIDTH-1:9], in_bit_1_2[RANGE_WIDTH-1:9],
                       in_bit_2_1[RANGE_WIDTH-1:9], in_bit_2_2[RANGE_WIDTH-1:9]};

  assign eff_1    = (in_flag_1 == 2'b11) ? 2'b00 : in_flag_1;
  assign eff_2    = (in_flag_2 == 2'b11) ? 2'b00 : in_flag_2;
  assign flag_bad = (in_flag_1 == 2'b11) || (in_flag_2 == 2'b11);

  // Word idx of the beat: slot 1 words first, then slot 2 starting at n1.
  always_comb begin
    cur_word = '0;
    if (stg_idx < {1'b0, stg_n1})
      cur_word = stg_idx[0] ? stg_w12 : stg_w11;
    else
      cur_word = (stg_idx[0] ^ stg_n1[0]) ? stg_w22 : stg_w21;
  end

  assign cur_c      = cur_word[8];
  assign cur_b      = cur_word[7:0];
  assign in_ready   = (state == ACCEPT) && !stg_valid && !flush_pend;
  assign load       = in_valid && in_ready;
  assign consume    = (state == ACCEPT) && stg_valid && (stg_cnt != 3'd0);
  assign word_emits = cur_c || (cur_b != 8'hFF);
  assign last_word  = (stg_idx == stg_cnt - 3'd1);
  assign stg_clear  = (state == ACCEPT) && stg_valid && ((stg_cnt == 3'd0) || last_word);
  assign flush_go   = (state == ACCEPT) && !stg_valid && flush_pend;
  assign hs         = out_valid && out_ready;
  assign flush_fin  = hs && (((state == FLUSH_HELD) && (emit_run == '0)) ||
                             ((state == FLUSH_RUN) && (emit_run == RUN_ONE)));

  always_ff @(posedge general_clk or negedge reset) begin
    if (!reset) state <= ACCEPT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCEPT: begin
        if (consume && word_emits && hv) state_nxt = EMIT_HELD;
        else if (flush_go && hv)         state_nxt = FLUSH_HELD;
      end
      EMIT_HELD:  if (hs) state_nxt = (emit_run != '0) ? EMIT_RUN : ACCEPT;
      EMIT_RUN:   if (hs && (emit_run == RUN_ONE)) state_nxt = ACCEPT;
      FLUSH_HELD: if (hs) state_nxt = (emit_run != '0) ? FLUSH_RUN : ACCEPT;
      FLUSH_RUN:  if (hs && (emit_run == RUN_ONE)) state_nxt = ACCEPT;
      default:    state_nxt = ACCEPT;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_byte  = 8'h00;
    out_last  = 1'b0;
    case (state)
      EMIT_HELD: begin
        out_valid = 1'b1;
        out_byte  = emit_byte;
      end
      EMIT_RUN: begin
        out_valid = 1'b1;
        out_byte  = fill;
      end
      FLUSH_HELD: begin
        out_valid = 1'b1;
        out_byte  = held;
        out_last  = (emit_run == '0);
      end
      FLUSH_RUN: begin
        out_valid = 1'b1;
        out_byte  = 8'hFF;
        out_last  = (emit_run == RUN_ONE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge general_clk or negedge reset) begin
    if (!reset) begin
      stg_valid  <= 1'b0;
      stg_n1     <= 2'b00;
      stg_cnt    <= 3'd0;
      stg_idx    <= 3'd0;
      stg_w11    <= '0;
      stg_w12    <= '0;
      stg_w21    <= '0;
      stg_w22    <= '0;
      held       <= 8'h00;
      hv         <= 1'b0;
      pend       <= '0;
      emit_byte  <= 8'h00;
      fill       <= 8'h00;
      emit_run   <= '0;
      flush_pend <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= flush_fin || (flush_go && !hv);

      if (load) begin
        stg_valid <= 1'b1;
        stg_n1    <= eff_1;
        stg_cnt   <= {1'b0, eff_1} + {1'b0, eff_2};
        stg_idx   <= 3'd0;
        stg_w11   <= in_bit_1_1[8:0];
        stg_w12   <= in_bit_1_2[8:0];
        stg_w21   <= in_bit_2_1[8:0];
        stg_w22   <= in_bit_2_2[8:0];
      end else if (stg_clear) begin
        stg_valid <= 1'b0;
      end

      if (in_ready && flush)
        flush_pend <= 1'b1;
      else if (flush_fin || (flush_go && !hv))
        flush_pend <= 1'b0;

      if (consume) begin
        stg_idx <= stg_idx + 3'd1;
        if (word_emits) begin
          emit_byte <= held + {7'b0, cur_c};
          emit_run  <= pend;
          fill      <= cur_c ? 8'h00 : 8'hFF;
          held      <= cur_b;
          hv        <= 1'b1;
          pend      <= '0;
        end else if (hv) begin
`ifdef CARRY_ERR_CHECK_EN
          if (!(&pend)) pend <= pend + RUN_ONE;
`else
          pend <= pend + RUN_ONE;
`endif
        end else begin
          held <= 8'hFF;
          hv   <= 1'b1;
          pend <= '0;
        end
      end

      if (flush_go && hv)
        emit_run <= pend;
      else if (hs && ((state == EMIT_RUN) || (state == FLUSH_RUN)))
        emit_run <= emit_run - RUN_ONE;

      if (flush_fin) begin
        hv   <= 1'b0;
        pend <= '0;
      end
    end
  end

`ifdef CARRY_ERR_CHECK_EN
  logic [1:0] err_q;

  always_ff @(posedge general_clk or negedge reset) begin
    if (!reset) begin
      err_q <= 2'b00;
    end else begin
      if (consume && !word_emits && hv && (&pend)) err_q[0] <= 1'b1;
      if ((load && flag_bad) || (consume && cur_c && !hv)) err_q[1] <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_err;
  assign unused_err = flag_bad;
  assign err        = 2'b00;
`endif

endmodule

// File: tb/tb_carry_propagation.sv
// Randomized scoreboard bench for carry_propagation; the reference model keeps
// unresolved bytes in a queue and ripples carries through it arithmetically.
module tb_carry_propagation;

  logic        general_clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_flag_1 = 2'b00, in_flag_2 = 2'b00;
  logic [15:0] in_bit_1_1 = '0, in_bit_1_2 = '0, in_bit_2_1 = '0, in_bit_2_2 = '0;
  logic        flush = 1'b0;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        flush_done;
  logic [1:0]  err;

  carry_propagation #(.RANGE_WIDTH(16), .RUN_CNT_WIDTH(16)) dut (
    .general_clk(general_clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_flag_1(in_flag_1), .in_flag_2(in_flag_2),
    .in_bit_1_1(in_bit_1_1), .in_bit_1_2(in_bit_1_2),
    .in_bit_2_1(in_bit_2_1), .in_bit_2_2(in_bit_2_2),
    .flush(flush), .out_byte(out_byte), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last),
    .flush_done(flush_done), .err(err)
  );

  always #5 general_clk = ~general_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_seen  = 0;
  int rdy_mode = 0;

  logic [8:0] exp_q[$];   // {last, byte} expected at the output
  logic [7:0] mq[$];      // unresolved bytes, oldest first
  logic [1:0] exp_err = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic void model_word(input logic [8:0] w);
    logic       c;
    logic [7:0] b;
    c = w[8];
    b = w[7:0];
    if (c) begin
      if (mq.size() == 0) begin
`ifdef CARRY_ERR_CHECK_EN
        exp_err[1] = 1'b1;
`endif
      end else begin
        for (int i = mq.size() - 1; i >= 0; i--) begin
          mq[i] = mq[i] + 8'd1;
          if (mq[i] != 8'h00) break;
        end
      end
    end
    if (c || b != 8'hFF || mq.size() == 0) begin
      foreach (mq[i]) exp_q.push_back({1'b0, mq[i]});
      mq.delete();
      mq.push_back(b);
    end else begin
      mq.push_back(8'hFF);
    end
  endfunction

  function automatic void model_flush();
    foreach (mq[i]) exp_q.push_back({(i == mq.size() - 1) ? 1'b1 : 1'b0, mq[i]});
    mq.delete();
  endfunction

  function automatic void model_beat(input logic [1:0] f1, input logic [1:0] f2,
                                     input logic [8:0] w11, input logic [8:0] w12,
                                     input logic [8:0] w21, input logic [8:0] w22);
    logic [1:0] e1, e2;
    e1 = (f1 == 2'b11) ? 2'b00 : f1;
    e2 = (f2 == 2'b11) ? 2'b00 : f2;
`ifdef CARRY_ERR_CHECK_EN
    if (f1 == 2'b11 || f2 == 2'b11) exp_err[1] = 1'b1;
`endif
    if (e1 >= 2'd1) model_word(w11);
    if (e1 == 2'd2) model_word(w12);
    if (e2 >= 2'd1) model_word(w21);
    if (e2 == 2'd2) model_word(w22);
  endfunction

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  initial begin
    logic       prev_stall;
    logic [8:0] prev_out;
    logic [8:0] e;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge general_clk);
      if (!reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", {31'b0, out_valid}, 32'd1);
          check("stall_data", {23'b0, out_last, out_byte}, {23'b0, prev_out});
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got %0h expected none", out_byte);
          end else begin
            e = exp_q.pop_front();
            check("out_byte_last", {23'b0, out_last, out_byte}, {23'b0, e});
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = {out_last, out_byte};
        if (flush_done) fd_seen++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge general_clk);
      #1;
      if (rdy_mode == 0)      out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = ($urandom % 3) != 0;
    end
  end

  task automatic send(input bit v, input logic [1:0] f1, input logic [1:0] f2,
                      input logic [8:0] w11, input logic [8:0] w12,
                      input logic [8:0] w21, input logic [8:0] w22, input bit fl);
    int  fd0;
    bit  ok;
    fd0 = fd_seen;
    in_valid   = v;
    in_flag_1  = f1;
    in_flag_2  = f2;
    in_bit_1_1 = {7'b0, w11};
    in_bit_1_2 = {7'b0, w12};
    in_bit_2_1 = {7'b0, w21};
    in_bit_2_2 = {7'b0, w22};
    flush      = fl;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge general_clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge general_clk);
      #1;
    end
    @(posedge general_clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    if (!ok) begin
      timeout("in_ready");
      return;
    end
    if (v) model_beat(f1, f2, w11, w12, w21, w22);
    if (fl) begin
      model_flush();
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        if (fd_seen > fd0) begin
          ok = 1'b1;
          break;
        end
        @(posedge general_clk);
        #1;
      end
      if (!ok) timeout("flush_done");
      repeat (2) @(posedge general_clk);
      #1;
      check("flush_done_once", fd_seen, fd0 + 1);
      check("drained", exp_q.size(), 0);
      check("err", {30'b0, err}, {30'b0, exp_err});
    end
  endtask

  task automatic word1(input logic [8:0] w);
    send(1'b1, 2'b01, 2'b00, w, 9'h0, 9'h0, 9'h0, 1'b0);
  endtask

  task automatic do_flush();
    send(1'b0, 2'b00, 2'b00, 9'h0, 9'h0, 9'h0, 9'h0, 1'b1);
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge general_clk);
      #1;
    end
    if (!ok) timeout("out_valid");
  endtask

  function automatic logic [8:0] rand_word();
    logic [8:0] w;
    w[8]   = ($urandom % 5) == 0;
    w[7:0] = (($urandom % 3) == 0) ? 8'hFF : 8'($urandom);
    return w;
  endfunction

  function automatic logic [1:0] rand_flag();
    int r;
    r = $urandom % 16;
    return (r == 0) ? 2'b11 : 2'(r % 3);
  endfunction

  initial begin
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_byte", {24'b0, out_byte}, 32'd0);
    check("rst_out_last", {31'b0, out_last}, 32'd0);
    check("rst_flush_done", {31'b0, flush_done}, 32'd0);
    check("rst_err", {30'b0, err}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (3) @(posedge general_clk);
    #1;
    reset = 1'b1;
    @(posedge general_clk);
    #1;

    // illegal flag, then an orphan carry on the first word
    send(1'b1, 2'b11, 2'b00, 9'h1AA, 9'h0, 9'h0, 9'h0, 1'b0);
    word1(9'h140);
    do_flush();

    word1(9'h012);
    word1(9'h034);
    do_flush();

    word1(9'h0A0); word1(9'h0FF); word1(9'h0FF); word1(9'h105);
    do_flush();

    send(1'b1, 2'b10, 2'b10, 9'h0A0, 9'h0FF, 9'h0FF, 9'h011, 1'b1);

    // backpressure during a 3-byte fill run
    rdy_mode  = 2;
    out_ready = 1'b0;
    send(1'b1, 2'b10, 2'b10, 9'h0A0, 9'h0FF, 9'h0FF, 9'h0FF, 1'b0);
    word1(9'h105);
    wait_valid();
    out_ready = 1'b1;
    @(posedge general_clk);
    #1;
    out_ready = 1'b0;
    repeat (5) @(posedge general_clk);
    #1;
    check("stalled_in_run", {31'b0, out_valid}, 32'd1);
    rdy_mode = 0;
    do_flush();

    // reset while two fill bytes remain
    rdy_mode  = 2;
    out_ready = 1'b0;
    send(1'b1, 2'b10, 2'b10, 9'h0A0, 9'h0FF, 9'h0FF, 9'h0FF, 1'b0);
    word1(9'h105);
    wait_valid();
    out_ready = 1'b1;
    repeat (2) @(posedge general_clk);
    #1;
    out_ready = 1'b0;
    #1;
    reset = 1'b0;
    exp_q.delete();
    mq.delete();
    exp_err = 2'b00;
    #1;
    check("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_mid_err", {30'b0, err}, 32'd0);
    repeat (2) @(posedge general_clk);
    #1;
    reset    = 1'b1;
    rdy_mode = 0;
    do_flush();

    // randomized traffic with random backpressure
    rdy_mode = 1;
    for (int n = 0; n < 80; n++) begin
      send(($urandom % 6) != 0, rand_flag(), rand_flag(),
           rand_word(), rand_word(), rand_word(), rand_word(),
           ($urandom % 8) == 0);
    end
    do_flush();
    rdy_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
